wb_stage_reg: RTL
=================

# wb_stage_reg

Parametrised pipeline stage register placed between the memory-access stage and the write-back stage of the five-stage core. It generalises the MEM/WB latch to WB_PORTS parallel register-file write channels, and adds a flush input, a valid bit and same-cycle write-conflict resolution. It keeps the HI/LO and LLbit side channels and the 6-bit stall-vector semantics. Optional saturating retire and bubble counters support performance analysis.

## Interface

- STAGE, 4, index of this latch's own bit in `stall`; bit STAGE+1 is the downstream stage.
- STALL_W, 6, width of the stall vector.
- WB_PORTS, 1, number of register-file write channels (1..4).
- ADDR_W, 5, register address width.
- DATA_W, 32, data width of GPR, HI and LO.
- CNT_W, 16, performance counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  pipeline stall vector; 1 = stop.
- flush  in  1  exception flush; kills the captured instruction.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_wd  in  WB_PORTS*ADDR_W  destination addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- mem_wreg  in  WB_PORTS  per-port write enable.
- mem_wdata  in  WB_PORTS*DATA_W  per-port write data.
- mem_hi, mem_lo  in  DATA_W each  HI/LO values.
- mem_whilo  in  1  HI/LO write enable.
- mem_LLbit_we, mem_LLbit_value  in  1 each  LLbit update.
- wb_valid  out  1  registered valid.
- wb_wd, wb_wreg, wb_wdata  out  as inputs  registered per-port write information.
- wb_hi, wb_lo, wb_whilo, wb_LLbit_we, wb_LLbit_value  out  registered side channels.
- wb_conflict  out  1  pulse: a port write was suppressed at the last capture.
- retire_cnt, bubble_cnt  out  CNT_W each  performance counters (see Configuration).

## Operation

- Update priority on each rising edge: rst, then flush, then bubble, then capture, then hold.
- **rst = 1:**
  - All outputs go to 0.
  - Every wb_wd lane becomes 0 (NOP register address).
  - Counters clear.
- **flush = 1:** load the same values as reset, except the counters, which are untouched. flush overrides any stall.
- **Bubble:** stall[STAGE]=1 and stall[STAGE+1]=0.
  - Load the reset values, except the counters.
  - bubble_cnt increments.
  - When STAGE = STALL_W-1, stall[STAGE+1] is treated as 0.
- **Capture:** stall[STAGE]=0.
  - All mem_* inputs are registered into the matching wb_* outputs.
  - wb_valid takes mem_valid.
  - If mem_valid=1, retire_cnt increments.
- **Hold:** stall[STAGE]=1 and stall[STAGE+1]=1. All outputs keep their values, including wb_conflict.
- **Write filtering at capture** (mem_valid=0 forces every wreg, whilo and LLbit_we to 0):
  - A port with wd = 0 has its wb_wreg forced to 0.
  - If ports i<j both have wreg=1 and equal nonzero wd, port i's wb_wreg is forced to 0 (the higher index wins).
  - When this happens, wb_conflict = 1 for that capture; otherwise wb_conflict = 0 on every capture, bubble or flush.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing

- Latency is 1 cycle, input to output, on capture.
- No combinational path from any input to any output.
- Reset is synchronous: it is only observed on the clock edge.
- Asserting rst mid-stall discards the held content on that edge.
- If flush and stall are both 1 in one cycle, the flush result appears next cycle.
- A hold of any length followed by a capture passes the then-current inputs; held data is not replayed.

## Configuration

- Macro: `WB_STAGE_PERF_CNT_EN`.
- **Defined:** retire_cnt and bubble_cnt behave as specified above.
- **Undefined:**
  - No counter flops are built.
  - retire_cnt and bubble_cnt are tied to 0.
  - All other behaviour is identical.

## Test plan

- **Reset/capture:**
  - rst=1 for 2 cycles, then rst=0, stall=0, mem_valid=1, port0 wd=5, wreg=1, wdata=0x1234_5678.
  - Required: all outputs 0 during reset; next edge wb_wd=5, wb_wdata=0x12345678, wb_valid=1, retire_cnt=1.
- **Bubble vs hold:**
  - stall=6'b011111 (STAGE=4, bit5=0) for 1 cycle → wb_wreg=0, wb_valid=0, bubble_cnt=1.
  - Then stall=6'b111111 for 3 cycles → outputs unchanged, counters unchanged.
- **Flush priority:** flush=1 with stall=0 and a valid HI/LO write (whilo=1, hi=0xA) → next edge wb_whilo=0, wb_hi=0, wb_valid=0, retire_cnt unchanged.
- **Conflict:**
  - WB_PORTS=2, both ports wd=7, wreg=1, data 0x11 and 0x22 → wb_wreg=2'b10, wb_wdata lane1=0x22, wb_conflict=1 for one capture.
  - Same test with wd0=0, wd1=3 → wb_wreg=2'b10, wb_conflict=0.
- **Saturation:** CNT_W=4, 20 consecutive valid captures → retire_cnt stops at 15.
- **Macro off:** rebuild without `WB_STAGE_PERF_CNT_EN`, repeat the first test → counters read 0, all datapath results identical.

Source files
------------

// File: rtl/wb_stage_reg.sv
// ----------------------------------------------------------------------------
// wb_stage_reg
//
// Pipeline latch between the memory-access and write-back stages. It carries
// WB_PORTS parallel register-file write channels plus the HI/LO and LLbit
// side channels and a valid bit. Same-cycle writes to the same register are
// resolved at capture (the highest port index wins), and the loss is flagged
// on wb_conflict.
//
// Optional feature macro: WB_STAGE_PERF_CNT_EN
//   defined   : saturating retire_cnt / bubble_cnt counters are built
//   undefined : no counter flops, retire_cnt / bubble_cnt tied to 0
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   stall[STALL_W]     stall vector (1 = stop); bit STAGE is this latch
//   flush              exception flush, kills the captured instruction
//   mem_*              MEM-stage results (valid, per-port wd/wreg/wdata,
//                      hi/lo/whilo, LLbit_we/LLbit_value)
//   wb_*               registered copies of the above
//   wb_conflict        a port write was suppressed at the last capture
//   retire_cnt         valid instructions captured (saturating)
//   bubble_cnt         bubbles inserted (saturating)
// ----------------------------------------------------------------------------
module wb_stage_reg #(
    parameter int STAGE    = 4,
    parameter int STALL_W  = 6,
    parameter int WB_PORTS = 1,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STALL_W-1:0]           stall,
    input  logic                         flush,
    input  logic                         mem_valid,
    input  logic [WB_PORTS*ADDR_W-1:0]   mem_wd,
    input  logic [WB_PORTS-1:0]          mem_wreg,
    input  logic [WB_PORTS*DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]            mem_hi,
    input  logic [DATA_W-1:0]            mem_lo,
    input  logic                         mem_whilo,
    input  logic                         mem_LLbit_we,
    input  logic                         mem_LLbit_value,
    output logic                         wb_valid,
    output logic [WB_PORTS*ADDR_W-1:0]   wb_wd,
    output logic [WB_PORTS-1:0]          wb_wreg,
    output logic [WB_PORTS*DATA_W-1:0]   wb_wdata,
    output logic [DATA_W-1:0]            wb_hi,
    output logic [DATA_W-1:0]            wb_lo,
    output logic                         wb_whilo,
    output logic                         wb_LLbit_we,
    output logic                         wb_LLbit_value,
    output logic                         wb_conflict,
    output logic [CNT_W-1:0]             retire_cnt,
    output logic [CNT_W-1:0]             bubble_cnt
);

    logic down_stall;

    // The last stage in the vector has no downstream neighbour.
    generate
        if (STAGE >= STALL_W-1) begin : g_last_stage
            assign down_stall = 1'b0;
        end else begin : g_mid_stage
            assign down_stall = stall[STAGE+1];
        end
    endgenerate

    logic own_stall;
    logic bubble;
    logic capture;
    logic clear;

    assign own_stall = stall[STAGE];
    assign bubble    = own_stall && !down_stall;
    assign capture   = !own_stall;
    assign clear     = rst || flush || bubble;

    logic [WB_PORTS-1:0] wreg_v;
    logic [WB_PORTS-1:0] wreg_f;
    logic                conflict_n;

    // Write filtering: drop writes to register 0 and, among ports aimed at
    // the same register, keep only the highest-index one.
    always_comb begin
        wreg_v     = mem_wreg & {WB_PORTS{mem_valid}};
        wreg_f     = wreg_v;
        conflict_n = 1'b0;
        for (int i = 0; i < WB_PORTS; i++) begin
            if (mem_wd[i*ADDR_W +: ADDR_W] == '0) begin
                wreg_f[i] = 1'b0;
            end
            for (int j = i + 1; j < WB_PORTS; j++) begin
                if (wreg_v[i] && wreg_v[j] &&
                    (mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W]) &&
                    (mem_wd[i*ADDR_W +: ADDR_W] != '0)) begin
                    wreg_f[i]  = 1'b0;
                    conflict_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wb_valid       <= 1'b0;
            wb_wd          <= '0;
            wb_wreg        <= '0;
            wb_wdata       <= '0;
            wb_hi          <= '0;
            wb_lo          <= '0;
            wb_whilo       <= 1'b0;
            wb_LLbit_we    <= 1'b0;
            wb_LLbit_value <= 1'b0;
            wb_conflict    <= 1'b0;
        end else if (capture) begin
            wb_valid       <= mem_valid;
            wb_wd          <= mem_wd;
            wb_wreg        <= wreg_f;
            wb_wdata       <= mem_wdata;
            wb_hi          <= mem_hi;
            wb_lo          <= mem_lo;
            wb_whilo       <= mem_whilo && mem_valid;
            wb_LLbit_we    <= mem_LLbit_we && mem_valid;
            wb_LLbit_value <= mem_LLbit_value;
            wb_conflict    <= conflict_n;
        end
    end

`ifdef WB_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else if (!flush) begin
            if (bubble && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
            if (capture && mem_valid && (retire_q != '1)) begin
                retire_q <= retire_q + 1'b1;
            end
        end
    end

    assign retire_cnt = retire_q;
    assign bubble_cnt = bubble_q;
`else
    assign retire_cnt = '0;
    assign bubble_cnt = '0;
`endif

endmodule
